cpu_opponent: RTL and testbench

Computer-controlled rival player for the tug-of-war game. It sits directly downstream of the random-bit generator and consumes its three outputs: rand (jitter bit), randfake (decoy select) and randspeed (fast/slow select). It turns them into timed single-cycle rope pushes, plus an optional decoy LED flash before each push. cpu_push feeds the rope-position logic in place of a second human button.

---
 rtl/cpu_opponent_pkg.sv | 27 ++
 rtl/cpu_opponent_dly_counter.sv | 28 ++
 rtl/cpu_opponent.sv | 132 +++++++++++++
 tb/tb_cpu_opponent.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/cpu_opponent_pkg.sv
// Shared types and helpers for the CPU tug-of-war opponent.
// State encoding is fixed so that debug probes read the same values on every build.
package cpu_opponent_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_ARM  = 3'd1,
        ST_WAIT = 3'd2,
        ST_FAKE = 3'd3,
        ST_PUSH = 3'd4,
        ST_COOL = 3'd5
    } state_e;

    localparam int unsigned PUSH_MAX = 255;

    // Unsigned add that clips at max_val instead of wrapping.
    function automatic logic [31:0] sat_add(
        input logic [31:0] a,
        input logic [31:0] b,
        input logic [31:0] max_val
    );
        logic [32:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        return (sum > {1'b0, max_val}) ? max_val : sum[31:0];
    endfunction

endpackage

// File: rtl/cpu_opponent_dly_counter.sv
// Loadable down-counter that stops at zero.
// It times the WAIT, FAKE and COOL phases of the opponent.
module cpu_opponent_dly_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_load,
    input  logic [CNT_W-1:0] i_load_val,
    output logic             o_zero
);

    logic [CNT_W-1:0] r_cnt;

    // NOTE: sequential state uses <= so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - CNT_W'(1);
        end
    end

    assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/cpu_opponent.sv
// CPU rival for the tug-of-war game: turns the random-bit generator outputs
// into timed single-cycle rope pushes, optionally preceded by a decoy flash.
module cpu_opponent
    import cpu_opponent_pkg::*;
#(
    parameter int FAST_DLY     = 2000,
    parameter int SLOW_DLY     = 6000,
    parameter int JITTER_SHIFT = 6,
    parameter int FAKE_LEN     = 500,
    parameter int COOL_LEN     = 1000,
    parameter int CNT_W        = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_game_en,
    input  logic       i_rand,
    input  logic       i_randfake,
    input  logic       i_randspeed,
    output logic       o_cpu_push,
    output logic       o_fake_led,
    output logic       o_busy,
    output logic [7:0] o_push_count
);

    localparam int DW      = CNT_W + 5;
    localparam int MAX_DLY = (2 ** CNT_W) - 1;

    state_e           r_state;
    state_e           w_next;
    logic [2:0]       r_hist;   // only the three bits that survive the next shift are kept
    logic             r_fake_sel;
    logic             r_cpu_push;
    logic             r_fake_led;
    logic             r_busy;
    logic [7:0]       r_push_count;

    logic [3:0]       w_hist_new;
    logic [DW-1:0]    w_base;
    logic [DW-1:0]    w_jit;
    logic [CNT_W-1:0] w_dly_sat;
    logic [CNT_W-1:0] w_dly;
    logic             w_load;
    logic [CNT_W-1:0] w_load_val;
    logic             w_cnt_zero;
    logic             w_arm_done;

    assign w_hist_new = {r_hist, i_rand};
    assign w_base     = i_randspeed ? DW'(FAST_DLY) : DW'(SLOW_DLY);
    assign w_jit      = DW'(w_hist_new) << JITTER_SHIFT;
    assign w_dly_sat  = CNT_W'(sat_add(32'(w_base), 32'(w_jit), 32'(MAX_DLY)));
    assign w_dly      = (w_dly_sat == '0) ? CNT_W'(1) : w_dly_sat;
    assign w_arm_done = (r_state == ST_ARM) && (w_next == ST_WAIT);

    cpu_opponent_dly_counter #(
        .CNT_W (CNT_W)
    ) u_dly_counter (
        .clk        (clk),
        .rst        (rst),
        .i_load     (w_load),
        .i_load_val (w_load_val),
        .o_zero     (w_cnt_zero)
    );

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        w_next     = r_state;
        w_load     = 1'b0;
        w_load_val = '0;
        unique case (r_state)
            ST_IDLE: if (i_game_en) w_next = ST_ARM;
            ST_ARM: begin
                w_next     = ST_WAIT;
                w_load     = 1'b1;
                w_load_val = w_dly - CNT_W'(1);
            end
            ST_WAIT: begin
                if (w_cnt_zero) begin
                    if (r_fake_sel) begin
                        w_next     = ST_FAKE;
                        w_load     = 1'b1;
                        w_load_val = CNT_W'(FAKE_LEN - 1);
                    end else begin
                        w_next = ST_PUSH;
                    end
                end
            end
            ST_FAKE: if (w_cnt_zero) w_next = ST_PUSH;
            ST_PUSH: begin
                w_next     = ST_COOL;
                w_load     = 1'b1;
                w_load_val = CNT_W'(COOL_LEN - 1);
            end
            ST_COOL: if (w_cnt_zero) w_next = i_game_en ? ST_ARM : ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
        // Losing game_en beats every other transition, so no push escapes after it.
        if (r_state != ST_IDLE && !i_game_en) w_next = ST_IDLE;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= ST_IDLE;
            r_hist       <= '0;
            r_fake_sel   <= 1'b0;
            r_cpu_push   <= 1'b0;
            r_fake_led   <= 1'b0;
            r_busy       <= 1'b0;
            r_push_count <= '0;
        end else begin
            r_state    <= w_next;
            // Outputs decode the next state so they line up with r_state.
            r_cpu_push <= (w_next == ST_PUSH);
            r_fake_led <= (w_next == ST_FAKE);
            r_busy     <= (w_next != ST_IDLE);
            if (w_arm_done) begin
                r_hist     <= w_hist_new[2:0];
                r_fake_sel <= i_randfake;
            end
            if (r_state == ST_IDLE && w_next == ST_ARM) begin
                r_push_count <= '0;
            end else if (r_state == ST_PUSH) begin
                r_push_count <= 8'(sat_add(32'(r_push_count), 32'd1, 32'(PUSH_MAX)));
            end
        end
    end

    assign o_cpu_push   = r_cpu_push;
    assign o_fake_led   = r_fake_led;
    assign o_busy       = r_busy;
    assign o_push_count = r_push_count;

endmodule

// File: tb/tb_cpu_opponent.sv
// Self-checking bench for cpu_opponent: directed and random rounds compared
// against a round-timeline model; a second instance covers the delay clamps.
module tb_cpu_opponent;

    localparam int FAKE_LEN = 5;
    localparam int COOL_LEN = 4;
    localparam int DLY_MAX  = 255;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       game_en [2];
    logic       rnd     [2];
    logic       rfake   [2];
    logic       rspeed  [2];
    logic       push_w  [2];
    logic       fake_w  [2];
    logic       busy_w  [2];
    logic [7:0] cnt_w   [2];

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state and per-instance parameters.
    int hist_m  [2];
    int count_m [2];
    int p_fast  [2] = '{10, 0};
    int p_slow  [2] = '{30, 250};
    int p_js    [2] = '{1, 4};
    int exp_w3  [4] = '{32, 36, 44, 60};

    cpu_opponent #(
        .FAST_DLY(10), .SLOW_DLY(30), .JITTER_SHIFT(1),
        .FAKE_LEN(FAKE_LEN), .COOL_LEN(COOL_LEN), .CNT_W(8)
    ) u_dut (
        .clk(clk), .rst(rst), .i_game_en(game_en[0]), .i_rand(rnd[0]),
        .i_randfake(rfake[0]), .i_randspeed(rspeed[0]), .o_cpu_push(push_w[0]),
        .o_fake_led(fake_w[0]), .o_busy(busy_w[0]), .o_push_count(cnt_w[0])
    );

    cpu_opponent #(
        .FAST_DLY(0), .SLOW_DLY(250), .JITTER_SHIFT(4),
        .FAKE_LEN(FAKE_LEN), .COOL_LEN(COOL_LEN), .CNT_W(8)
    ) u_sat (
        .clk(clk), .rst(rst), .i_game_en(game_en[1]), .i_rand(rnd[1]),
        .i_randfake(rfake[1]), .i_randspeed(rspeed[1]), .o_cpu_push(push_w[1]),
        .o_fake_led(fake_w[1]), .o_busy(busy_w[1]), .o_push_count(cnt_w[1])
    );

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // Model of the ARM decision: shift history, add jitter, clamp to [1, 255].
    task automatic model_arm(input int u, input bit r, input bit s, output int d);
        hist_m[u] = ((hist_m[u] * 2) + int'(r)) % 16;
        d = (s ? p_fast[u] : p_slow[u]) + hist_m[u] * (2 ** p_js[u]);
        if (d > DLY_MAX) d = DLY_MAX;
        if (d < 1) d = 1;
    endtask

    // Called at the negedge just before ARM is entered; returns at the last cooldown cycle.
    task automatic round(input int u, input bit r, input bit f, input bit s,
                         input bit fresh, output int w_meas);
        int d, exp_push, c, push_at, fake_first, fake_n;
        game_en[u] = 1'b1;
        rnd[u]     = r;
        rfake[u]   = f;
        rspeed[u]  = s;
        model_arm(u, r, s, d);
        if (fresh) count_m[u] = 0;
        exp_push   = d + 2 + (f ? FAKE_LEN : 0);
        c          = 0;
        push_at    = -1;
        fake_first = -1;
        fake_n     = 0;
        while (push_at < 0 && c < 600) begin
            @(negedge clk);
            c++;
            if (c == 1) check("arm_outputs", int'({busy_w[u], fake_w[u], push_w[u]}), 4);
            if (fake_w[u]) begin
                if (fake_first < 0) fake_first = c;
                fake_n++;
            end
            if (push_w[u]) begin
                push_at = c;
                check("fake_off_at_push", int'(fake_w[u]), 0);
            end
        end
        check("push_cycle", push_at, exp_push);
        check("fake_start", fake_first, f ? d + 2 : -1);
        check("fake_len", fake_n, f ? FAKE_LEN : 0);
        w_meas = (f ? fake_first : push_at) - 2;
        if (count_m[u] < 255) count_m[u]++;
        for (int k = 1; k <= COOL_LEN; k++) begin
            @(negedge clk);
            check("cool_outputs", int'({busy_w[u], fake_w[u], push_w[u]}), 4);
            if (k == 1) check("push_count", int'(cnt_w[u]), count_m[u]);
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation exceeded its time budget");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int w, d, pushes;
        rst = 1'b0;
        for (int u = 0; u < 2; u++) begin
            game_en[u] = 1'b0; rnd[u] = 1'b0; rfake[u] = 1'b0; rspeed[u] = 1'b0;
            hist_m[u]  = 0;    count_m[u] = 0;
        end
        #3;
        for (int u = 0; u < 2; u++) begin
            check("rst_outputs", int'({busy_w[u], fake_w[u], push_w[u]}), 0);
            check("rst_count", int'(cnt_w[u]), 0);
        end
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("idle_busy", int'(busy_w[0]), 0);

        // Basic push, then a decoy round.
        round(0, 1'b0, 1'b0, 1'b1, 1'b1, w);
        check("basic_wait", w, 10);
        round(0, 1'b0, 1'b1, 1'b1, 1'b0, w);
        check("decoy_wait", w, 10);

        // History fills with ones: hist 1, 3, 7, 15 on the slow base.
        for (int i = 0; i < 4; i++) begin
            round(0, 1'b1, 1'b0, 1'b0, 1'b0, w);
            check("jitter_wait", w, exp_w3[i]);
        end

        for (int i = 0; i < 12; i++)
            round(0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)), 1'b0, w);

        // Abort during WAIT cycle 5.
        rnd[0] = 1'b0; rfake[0] = 1'b0; rspeed[0] = 1'b1;
        model_arm(0, 1'b0, 1'b1, d);
        repeat (6) @(negedge clk);
        check("abort_in_wait", int'({busy_w[0], fake_w[0], push_w[0]}), 4);
        game_en[0] = 1'b0;
        @(negedge clk);
        check("abort_busy", int'(busy_w[0]), 0);
        pushes = 0;
        repeat (20) begin
            @(negedge clk);
            if (push_w[0]) pushes++;
        end
        check("abort_no_push", pushes, 0);
        check("abort_count", int'(cnt_w[0]), count_m[0]);

        // Reset asserted mid-FAKE, between clock edges.
        game_en[0] = 1'b1; rnd[0] = 1'b0; rfake[0] = 1'b1; rspeed[0] = 1'b1;
        model_arm(0, 1'b0, 1'b1, d);
        repeat (d + 4) @(negedge clk);
        check("fake_before_rst", int'(fake_w[0]), 1);
        #2;
        rst = 1'b0;
        #1;
        check("rst_async_outputs", int'({busy_w[0], fake_w[0], push_w[0]}), 0);
        check("rst_async_count", int'(cnt_w[0]), 0);
        game_en[0] = 1'b0;
        hist_m[0]  = 0; hist_m[1]  = 0;
        count_m[0] = 0; count_m[1] = 0;
        @(negedge clk);
        rst = 1'b1;
        repeat (5) @(negedge clk);
        check("post_rst_idle", int'(busy_w[0]), 0);
        round(0, 1'b0, 1'b0, 1'b1, 1'b1, w);
        check("post_rst_wait", w, 10);

        // Push counter saturation over many random rounds.
        for (int i = 0; i < 260; i++)
            round(0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)), 1'b0, w);
        check("count_sat", int'(cnt_w[0]), 255);
        game_en[0] = 1'b0;
        repeat (3) @(negedge clk);
        check("count_hold_idle", int'({busy_w[0], cnt_w[0]}), 255);

        // Delay clamps: zero forced to one, overflow clipped to 255.
        round(1, 1'b0, 1'b0, 1'b1, 1'b1, w);
        check("zero_dly_wait", w, 1);
        for (int i = 0; i < 4; i++) begin
            round(1, 1'b1, 1'b0, 1'b0, 1'b0, w);
            check("sat_dly_wait", w, 255);
        end
        game_en[1] = 1'b0;
        repeat (2) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
